led_pwm_duty_monitor: RTL and testbench

- Receive-side counterpart of the LED PWM drivers: samples the 8 active-low LED drive lines and measures each channel's lit duty over a fixed window.
- Reports the measured duties through a read port, plus the index of the brightest channel.
- Used as an on-chip self-check and brightness readback beside the LED mode drivers; sits on the same clk/rst_n domain.

---
 rtl/led_pwm_duty_monitor.sv | 174 +++++++++++++++++
 tb/tb_led_pwm_duty_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_duty_monitor.sv
// led_pwm_duty_monitor: measures the lit duty of 8 active-low LED drive
// lines over a fixed window of PERIOD clocks, snapshots the counts, then
// scans the snapshot for the brightest channel (ties keep the lower index).
// Optional build macro: PWM_MON_GLITCH_FILTER_EN adds a 3-tap majority
// filter after the synchronizer so single-cycle pulses are ignored.
module led_pwm_duty_monitor #(
  parameter int PERIOD = 2401,
  parameter int CNT_W  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       led_in,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_duty,
  output logic [CNT_W-1:0] max_duty,
  output logic [2:0]       brightest,
  output logic             duty_valid
);

  generate
    if (PERIOD < 10 || PERIOD > 4095 || (2**CNT_W) <= PERIOD) begin : g_bad_param
      $error("led_pwm_duty_monitor: PERIOD must be 10..4095 and below 2**CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  logic [7:0]       r_sync_p0, r_sync_p1;
  logic [7:0]       w_lit_raw, w_lit;
  logic [CNT_W-1:0] r_wcnt;
  logic             w_last;
  logic [CNT_W-1:0] r_acc  [8];
  logic [CNT_W-1:0] r_duty [8];

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_run_max, w_run_max_nxt;
  logic [2:0]       r_run_idx, w_run_idx_nxt;
  logic             w_done;
  logic [CNT_W-1:0] r_max_duty;
  logic [2:0]       r_brightest;
  logic             r_valid;

  // Two-flop synchronizer; idles at 1 (LED dark) out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p0 <= 8'hFF;
      r_sync_p1 <= 8'hFF;
    end else begin
      r_sync_p0 <= led_in;
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_lit_raw = ~r_sync_p1;

`ifdef PWM_MON_GLITCH_FILTER_EN
  logic [7:0] r_tap_p2, r_tap_p3;

  // Delay taps for the majority vote; reset to "not lit".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tap_p2 <= 8'h00;
      r_tap_p3 <= 8'h00;
    end else begin
      r_tap_p2 <= w_lit_raw;
      r_tap_p3 <= r_tap_p2;
    end
  end

  // Two of three consecutive samples must agree, so an isolated cycle never wins.
  assign w_lit = (w_lit_raw & r_tap_p2) | (w_lit_raw & r_tap_p3) | (r_tap_p2 & r_tap_p3);
`else
  assign w_lit = w_lit_raw;
`endif

  assign w_last = (r_wcnt == LAST);

  // Free-running window counter, back-to-back windows with no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wcnt <= '0;
    else if (w_last) r_wcnt <= '0;
    else r_wcnt <= r_wcnt + ONE;
  end

  // Per-channel accumulation; the last window cycle is folded into the snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_acc[i]  <= '0;
        r_duty[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_last) begin
          r_duty[i] <= r_acc[i] + CNT_W'(w_lit[i]);
          r_acc[i]  <= '0;
        end else begin
          r_acc[i]  <= r_acc[i] + CNT_W'(w_lit[i]);
        end
      end
    end
  end

  // Scan FSM next-state: one channel per cycle, strict greater-than keeps ties low.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_run_max_nxt = r_run_max;
    w_run_idx_nxt = r_run_idx;
    w_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_last) begin
          w_state_nxt   = S_SCAN;
          w_idx_nxt     = 3'd0;
          w_run_max_nxt = '0;
          w_run_idx_nxt = 3'd0;
        end
      end
      S_SCAN: begin
        if (r_duty[r_idx] > r_run_max) begin
          w_run_max_nxt = r_duty[r_idx];
          w_run_idx_nxt = r_idx;
        end
        w_idx_nxt = r_idx + 3'd1;
        if (r_idx == 3'd7) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Scan FSM state and running-max registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= 3'd0;
      r_run_max <= '0;
      r_run_idx <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_run_max <= w_run_max_nxt;
      r_run_idx <= w_run_idx_nxt;
    end
  end

  // Publish scan result together with the one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max_duty  <= '0;
      r_brightest <= 3'd0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_max_duty  <= w_run_max_nxt;
        r_brightest <= w_run_idx_nxt;
      end
    end
  end

  assign rd_duty    = r_duty[rd_sel];
  assign max_duty   = r_max_duty;
  assign brightest  = r_brightest;
  assign duty_valid = r_valid;

endmodule

// File: tb/tb_led_pwm_duty_monitor.sv
// Directed bench for led_pwm_duty_monitor: a PERIOD=16 instance for most
// scenarios and a PERIOD=2401 instance for the full-on readback.
module tb_led_pwm_duty_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  led16 = 8'hFF;
  logic [7:0]  ledb  = 8'hFF;
  logic [2:0]  sel16 = 3'd0;
  logic [2:0]  selb  = 3'd0;
  logic [11:0] rd16, max16, rdb, maxb;
  logic [2:0]  br16, brb;
  logic        v16, vb;
  int          checks = 0;
  int          errors = 0;
  int          cyc;

`ifdef PWM_MON_GLITCH_FILTER_EN
  localparam int LAT = 3;
  localparam int GLITCH_DUTY = 0;
`else
  localparam int LAT = 2;
  localparam int GLITCH_DUTY = 4;
`endif

  always #5 clk = ~clk;

  // Posedges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  led_pwm_duty_monitor #(.PERIOD(16), .CNT_W(12)) dut16 (
    .clk(clk), .rst_n(rst_n), .led_in(led16), .rd_sel(sel16),
    .rd_duty(rd16), .max_duty(max16), .brightest(br16), .duty_valid(v16)
  );

  led_pwm_duty_monitor #(.PERIOD(2401), .CNT_W(12)) dutb (
    .clk(clk), .rst_n(rst_n), .led_in(ledb), .rd_sel(selb),
    .rd_duty(rdb), .max_duty(maxb), .brightest(brb), .duty_valid(vb)
  );

  function automatic logic [7:0] pat_two(input int n);
    logic [7:0] l;
    l = 8'hFF;
    if ((n % 16) < 10) l[5] = 1'b0;
    if ((n % 16) < 12) l[6] = 1'b0;
    return l;
  endfunction

  function automatic logic [7:0] pat_glitch(input int n);
    logic [7:0] l;
    l = 8'hFF;
    if ((n % 4) == 0) l[0] = 1'b0;
    return l;
  endfunction

  task automatic hold_reset(input logic [7:0] l16, input logic [7:0] lb);
    @(negedge clk);
    rst_n = 1'b0;
    led16 = l16;
    ledb  = lb;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_v16(input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (v16 === 1'b1) break;
    end
    checks++;
    if (v16 !== 1'b1) begin
      $display("FAIL wait_v16: duty_valid=%b required 1 within %0d cycles", v16, bound);
      errors++;
    end
  endtask

  task automatic wait_vb(input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (vb === 1'b1) break;
    end
    checks++;
    if (vb !== 1'b1) begin
      $display("FAIL wait_vb: duty_valid=%b required 1 within %0d cycles", vb, bound);
      errors++;
    end
  endtask

  task automatic test_reset;
    hold_reset(8'hFF, 8'hFF);
    checks++; if (v16 !== 1'b0)   begin $display("FAIL rst_valid: got %b required 0", v16); errors++; end
    checks++; if (max16 !== 12'd0) begin $display("FAIL rst_max: got %0d required 0", max16); errors++; end
    checks++; if (br16 !== 3'd0)  begin $display("FAIL rst_bright: got %0d required 0", br16); errors++; end
    checks++; if (rd16 !== 12'd0) begin $display("FAIL rst_rd: got %0d required 0", rd16); errors++; end
    checks++; if (rdb !== 12'd0)  begin $display("FAIL rst_rd_big: got %0d required 0", rdb); errors++; end
    checks++; if (vb !== 1'b0)    begin $display("FAIL rst_valid_big: got %b required 0", vb); errors++; end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_dark;
    hold_reset(8'hFF, 8'hFF);
    rst_n = 1'b1;
    wait_v16(60);
    checks++; if (cyc != 24) begin $display("FAIL dark_latency: got %0d required 24", cyc); errors++; end
    checks++; if (max16 !== 12'd0) begin $display("FAIL dark_max: got %0d required 0", max16); errors++; end
    checks++; if (br16 !== 3'd0) begin $display("FAIL dark_bright: got %0d required 0", br16); errors++; end
    for (int s = 0; s < 8; s++) begin
      sel16 = 3'(s);
      #1;
      checks++;
      if (rd16 !== 12'd0) begin $display("FAIL dark_rd%0d: got %0d required 0", s, rd16); errors++; end
    end
    @(negedge clk);
    checks++; if (v16 !== 1'b0) begin $display("FAIL dark_pulse_width: got %b required 0", v16); errors++; end
    wait_v16(60);
    checks++; if (cyc != 40) begin $display("FAIL dark_second: got %0d required 40", cyc); errors++; end
    checks++; if (max16 !== 12'd0) begin $display("FAIL dark_max2: got %0d required 0", max16); errors++; end
  endtask

  task automatic test_single_channel;
    hold_reset(8'hF7, 8'hFF);
    rst_n = 1'b1;
    wait_v16(60);
    checks++; if (max16 !== 12'(16 - LAT)) begin $display("FAIL ch3_first_max: got %0d required %0d", max16, 16 - LAT); errors++; end
    wait_v16(60);
    checks++; if (cyc != 40) begin $display("FAIL ch3_latency: got %0d required 40", cyc); errors++; end
    checks++; if (max16 !== 12'd16) begin $display("FAIL ch3_max: got %0d required 16", max16); errors++; end
    checks++; if (br16 !== 3'd3) begin $display("FAIL ch3_bright: got %0d required 3", br16); errors++; end
    for (int s = 0; s < 8; s++) begin
      sel16 = 3'(s);
      #1;
      checks++;
      if (rd16 !== ((s == 3) ? 12'd16 : 12'd0)) begin
        $display("FAIL ch3_rd%0d: got %0d required %0d", s, rd16, (s == 3) ? 16 : 0);
        errors++;
      end
    end
  endtask

  task automatic test_two_channels;
    hold_reset(pat_two(0), 8'hFF);
    rst_n = 1'b1;
    for (int k = 0; k < 56; k++) begin
      @(negedge clk);
      led16 = pat_two(cyc);
    end
    checks++; if (v16 !== 1'b1) begin $display("FAIL two_valid: got %b required 1", v16); errors++; end
    checks++; if (max16 !== 12'd12) begin $display("FAIL two_max: got %0d required 12", max16); errors++; end
    checks++; if (br16 !== 3'd6) begin $display("FAIL two_bright: got %0d required 6", br16); errors++; end
    sel16 = 3'd5; #1;
    checks++; if (rd16 !== 12'd10) begin $display("FAIL two_rd5: got %0d required 10", rd16); errors++; end
    sel16 = 3'd6; #1;
    checks++; if (rd16 !== 12'd12) begin $display("FAIL two_rd6: got %0d required 12", rd16); errors++; end
    sel16 = 3'd0; #1;
    checks++; if (rd16 !== 12'd0) begin $display("FAIL two_rd0: got %0d required 0", rd16); errors++; end
  endtask

  task automatic test_reset_mid;
    hold_reset(8'h00, 8'hFF);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (max16 !== 12'(16 - LAT)) begin $display("FAIL mid_pre_max: got %0d required %0d", max16, 16 - LAT); errors++; end
    rst_n = 1'b0;
    led16 = 8'hFD;
    sel16 = 3'd0;
    #1;
    checks++; if (max16 !== 12'd0) begin $display("FAIL mid_max: got %0d required 0", max16); errors++; end
    checks++; if (br16 !== 3'd0) begin $display("FAIL mid_bright: got %0d required 0", br16); errors++; end
    checks++; if (v16 !== 1'b0) begin $display("FAIL mid_valid: got %b required 0", v16); errors++; end
    checks++; if (rd16 !== 12'd0) begin $display("FAIL mid_rd0: got %0d required 0", rd16); errors++; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_v16(60);
    checks++; if (cyc != 24) begin $display("FAIL mid_latency: got %0d required 24", cyc); errors++; end
    checks++; if (br16 !== 3'd1) begin $display("FAIL mid_bright2: got %0d required 1", br16); errors++; end
    checks++; if (max16 !== 12'(16 - LAT)) begin $display("FAIL mid_max2: got %0d required %0d", max16, 16 - LAT); errors++; end
    sel16 = 3'd1; #1;
    checks++; if (rd16 !== 12'(16 - LAT)) begin $display("FAIL mid_rd1: got %0d required %0d", rd16, 16 - LAT); errors++; end
    sel16 = 3'd0; #1;
    checks++; if (rd16 !== 12'd0) begin $display("FAIL mid_rd0_post: got %0d required 0", rd16); errors++; end
  endtask

  task automatic test_glitch;
    hold_reset(pat_glitch(0), 8'hFF);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      led16 = pat_glitch(cyc);
    end
    checks++; if (v16 !== 1'b1) begin $display("FAIL glitch_valid: got %b required 1", v16); errors++; end
    sel16 = 3'd0; #1;
    checks++; if (rd16 !== 12'(GLITCH_DUTY)) begin $display("FAIL glitch_rd0: got %0d required %0d", rd16, GLITCH_DUTY); errors++; end
    checks++; if (max16 !== 12'(GLITCH_DUTY)) begin $display("FAIL glitch_max: got %0d required %0d", max16, GLITCH_DUTY); errors++; end
    checks++; if (br16 !== 3'd0) begin $display("FAIL glitch_bright: got %0d required 0", br16); errors++; end
  endtask

  task automatic test_full_on_big;
    hold_reset(8'hFF, 8'h00);
    rst_n = 1'b1;
    wait_vb(2500);
    checks++; if (cyc != 2409) begin $display("FAIL big_latency: got %0d required 2409", cyc); errors++; end
    checks++; if (maxb !== 12'(2401 - LAT)) begin $display("FAIL big_first_max: got %0d required %0d", maxb, 2401 - LAT); errors++; end
    wait_vb(2500);
    checks++; if (cyc != 4810) begin $display("FAIL big_second: got %0d required 4810", cyc); errors++; end
    checks++; if (maxb !== 12'd2401) begin $display("FAIL big_max: got %0d required 2401", maxb); errors++; end
    checks++; if (brb !== 3'd0) begin $display("FAIL big_bright: got %0d required 0", brb); errors++; end
    for (int s = 0; s < 8; s++) begin
      selb = 3'(s);
      #1;
      checks++;
      if (rdb !== 12'd2401) begin $display("FAIL big_rd%0d: got %0d required 2401", s, rdb); errors++; end
    end
  endtask

  initial begin
    test_reset();
    test_idle_dark();
    test_single_channel();
    test_two_channels();
    test_reset_mid();
    test_glitch();
    test_full_on_big();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
